mci_mcu_trace_trigger_ctrl: RTL and testbench
=============================================

Name: mci_mcu_trace_trigger_ctrl

Overview:
Capture controller that sequences writes into the MCU trace buffer.
- Gates the per-packet write enable so the buffer records continuously while armed.
- Detects a programmable trigger (immediate, address match or exception/interrupt).
- Records post-trigger packets until a programmed count is reached, then freezes the buffer so the pre- and post-trigger history survives for DMI/CIF readout.
- Sits in MCI between the MCU trace port and the trace buffer write path. Its configuration is driven from MCI CSRs.

Parameters:
PTR_WIDTH, 6, width of the trace-buffer entry write pointer (64 entries)
CNT_WIDTH, 16, width of post-trigger and captured-packet counters

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
debug_en  input  1  debug unlock; low forces IDLE
trace_valid  input  1  MCU trace packet valid (rv_i_valid_ip)
trace_address  input  32  MCU trace rv_i_address_ip
trace_exception  input  1  MCU trace rv_i_exception_ip
trace_interrupt  input  1  MCU trace rv_i_interrupt_ip
buf_write_ptr  input  PTR_WIDTH  current trace-buffer entry write pointer
cfg_arm  input  1  single-cycle arm pulse
cfg_disarm  input  1  single-cycle disarm pulse
cfg_trig_mode  input  2  0=immediate, 1=address match, 2=exception or interrupt, 3=reserved (never triggers)
cfg_trig_addr  input  32  trigger address
cfg_trig_mask  input  32  address compare mask; 1=bit compared
cfg_post_count  input  CNT_WIDTH  packets to capture after the trigger packet
capture_en  output  1  write enable to the trace buffer
state  output  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE
triggered  output  1  sticky; trigger seen since the last arm
trig_ptr  output  PTR_WIDTH  buffer entry index holding the trigger packet
captured_cnt  output  CNT_WIDTH  packets written since arm, saturating

Behaviour:
- Reset: state=IDLE; triggered=0; trig_ptr=0; captured_cnt=0; internal latched config=0; post counter=0.
- capture_en is combinational: trace_valid & debug_en & (state==ARMED | state==POST). There are zero cycles of latency between a packet and its write enable.
- Arming:
  - cfg_arm is accepted only in IDLE or DONE.
  - On acceptance: latch cfg_trig_mode/addr/mask/post_count, clear triggered, trig_ptr and captured_cnt, then go to ARMED the next cycle.
  - cfg_arm in ARMED or POST is ignored.
- Trigger match, evaluated only in ARMED on a trace_valid cycle:
  - mode 0: any valid packet.
  - mode 1: ((trace_address ^ trig_addr) & trig_mask)==0.
  - mode 2: trace_exception | trace_interrupt.
  - mode 3: never.
- On trigger: the trigger packet itself is captured.
  - trig_ptr<=buf_write_ptr and triggered<=1.
  - If latched post_count==0, go to DONE. Otherwise load the post counter with post_count and go to POST.
- POST: each capture_en cycle decrements the post counter. The cycle that decrements it from 1 to 0 moves to DONE; that packet is captured.
- DONE: capture_en=0, so the buffer is frozen. Only arm, disarm or a debug_en drop leaves DONE.
- captured_cnt increments on every capture_en cycle and saturates at all-ones.
- Priority, highest first: rst > debug_en low > cfg_disarm > cfg_arm > trigger/count progression.
  - debug_en low or cfg_disarm forces IDLE next cycle. triggered, trig_ptr and captured_cnt hold their values.
  - In DONE, if cfg_disarm and cfg_arm are both asserted, the result is IDLE.
- A disarm in the same cycle as a valid packet in ARMED/POST: capture_en is still asserted for that cycle; the state becomes IDLE next cycle.
- Reset in mid-POST: IDLE with all outputs cleared next cycle. No partial count is retained.
- Wrap-around: buf_write_ptr wrap is transparent. trig_ptr is stored modulo 2^PTR_WIDTH.
- Config inputs changing after arm have no effect until the next arm.
- Counter arithmetic is unsigned CNT_WIDTH bits. The post counter never underflows, because the exit happens at 1→0.

Test Plan:
- Immediate trigger: arm with mode0, post_count=3; send 5 valid packets with buf_write_ptr=10..14 → capture_en high for packets 1-4, state DONE after the 4th, trig_ptr=10, captured_cnt=4, packet 5 not written.
- Address mask: mode1, trig_addr=0x2000_0100, mask=0xFFFF_FF00, post_count=2; send addresses 0x1000_0000, 0x2000_01F4, 0x2000_0000, 0x3000_0000, 0x4000_0000 → trigger on the 2nd packet, DONE after the 4th, captured_cnt=4, triggered=1.
- Exception trigger with post_count=0: mode2; the 3rd valid packet has trace_interrupt=1 → state DONE the next cycle, captured_cnt=3, subsequent valids give capture_en=0.
- Disarm/debug_en: in POST with counter=5, pulse cfg_disarm together with trace_valid → capture_en=1 that cycle, IDLE next cycle, triggered stays 1. Re-arm, then drop debug_en in ARMED → IDLE and capture_en=0 immediately.
- Arm ignored and reset: cfg_arm pulse during POST → the counter keeps decrementing unaffected. Assert rst during POST → state=IDLE, triggered=0, trig_ptr=0, captured_cnt=0 next cycle.
- Saturation/wrap: CNT_WIDTH=4, mode3, 20 valid packets → captured_cnt=15, state stays ARMED, capture_en=1 for all 20.

Source files
------------

// File: rtl/mci_mcu_trace_trigger_ctrl.sv
// Trace-buffer capture sequencer: gates buffer writes while armed, detects the
// programmed trigger, records the post-trigger window, then freezes the buffer.
module mci_mcu_trace_trigger_ctrl #(
    parameter int PTR_WIDTH = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 debug_en,
    input  logic                 trace_valid,
    input  logic [31:0]          trace_address,
    input  logic                 trace_exception,
    input  logic                 trace_interrupt,
    input  logic [PTR_WIDTH-1:0] buf_write_ptr,
    input  logic                 cfg_arm,
    input  logic                 cfg_disarm,
    input  logic [1:0]           cfg_trig_mode,
    input  logic [31:0]          cfg_trig_addr,
    input  logic [31:0]          cfg_trig_mask,
    input  logic [CNT_WIDTH-1:0] cfg_post_count,
    output logic                 capture_en,
    output logic [1:0]           state,
    output logic                 triggered,
    output logic [PTR_WIDTH-1:0] trig_ptr,
    output logic [CNT_WIDTH-1:0] captured_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] POST  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] MODE_IMM  = 2'd0;
    localparam logic [1:0] MODE_ADDR = 2'd1;
    localparam logic [1:0] MODE_EXC  = 2'd2;

    logic [1:0]           state_r;
    logic [1:0]           state_next;

    logic [1:0]           lat_mode;
    logic [31:0]          lat_addr;
    logic [31:0]          lat_mask;
    logic [CNT_WIDTH-1:0] lat_post;
    logic [CNT_WIDTH-1:0] post_left;

    logic                 force_idle;
    logic                 arm_ok;
    logic                 trig_match;
    logic                 trig_hit;
    logic                 post_step;
    logic                 post_last;

    // Control decode, in priority order below reset: debug lock, disarm, arm.
    assign force_idle = !debug_en || cfg_disarm;
    assign arm_ok     = cfg_arm && !force_idle && (state_r == IDLE || state_r == DONE);

    always_comb begin
        trig_match = 1'b0;
        case (lat_mode)
            MODE_IMM:  trig_match = 1'b1;
            MODE_ADDR: trig_match = ((trace_address ^ lat_addr) & lat_mask) == 32'd0;
            MODE_EXC:  trig_match = trace_exception || trace_interrupt;
            default:   trig_match = 1'b0;
        endcase
    end

    assign trig_hit  = capture_en && !force_idle && (state_r == ARMED) && trig_match;
    assign post_step = capture_en && !force_idle && (state_r == POST);
    // Exit on the 1->0 transition so the counter can never underflow.
    assign post_last = post_step && (post_left == CNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    always_comb begin
        state_next = state_r;
        if (force_idle) begin
            state_next = IDLE;
        end else if (arm_ok) begin
            state_next = ARMED;
        end else begin
            case (state_r)
                ARMED: begin
                    if (trig_hit) begin
                        state_next = (lat_post == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (post_last) begin
                        state_next = DONE;
                    end
                end
                default: state_next = state_r;
            endcase
        end
    end

    always_comb begin
        capture_en = trace_valid && debug_en && (state_r == ARMED || state_r == POST);
    end

    assign state = state_r;

    // Config latch, trigger record and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_mode     <= '0;
            lat_addr     <= '0;
            lat_mask     <= '0;
            lat_post     <= '0;
            post_left    <= '0;
            triggered    <= 1'b0;
            trig_ptr     <= '0;
            captured_cnt <= '0;
        end else if (arm_ok) begin
            lat_mode     <= cfg_trig_mode;
            lat_addr     <= cfg_trig_addr;
            lat_mask     <= cfg_trig_mask;
            lat_post     <= cfg_post_count;
            triggered    <= 1'b0;
            trig_ptr     <= '0;
            captured_cnt <= '0;
        end else begin
            if (trig_hit) begin
                triggered <= 1'b1;
                trig_ptr  <= buf_write_ptr;
                post_left <= lat_post;
            end else if (post_step) begin
                post_left <= post_left - CNT_WIDTH'(1);
            end
            if (capture_en && captured_cnt != '1) begin
                captured_cnt <= captured_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mci_mcu_trace_trigger_ctrl.sv
// Randomized and directed bench for the trace trigger controller, checked
// cycle by cycle against a behavioural model of the capture rules.
module tb_mci_mcu_trace_trigger_ctrl;

    localparam int PW = 6;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          debug_en;
    logic          trace_valid;
    logic [31:0]   trace_address;
    logic          trace_exception;
    logic          trace_interrupt;
    logic [PW-1:0] buf_write_ptr;
    logic          cfg_arm;
    logic          cfg_disarm;
    logic [1:0]    cfg_trig_mode;
    logic [31:0]   cfg_trig_addr;
    logic [31:0]   cfg_trig_mask;
    logic [CW-1:0] cfg_post_count;
    logic          capture_en;
    logic [1:0]    state;
    logic          triggered;
    logic [PW-1:0] trig_ptr;
    logic [CW-1:0] captured_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_state, m_trig, m_ptr, m_cnt, m_left;
    int m_mode, m_post;
    logic [31:0] m_addr, m_mask;

    mci_mcu_trace_trigger_ctrl #(.PTR_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .debug_en(debug_en), .trace_valid(trace_valid),
        .trace_address(trace_address), .trace_exception(trace_exception),
        .trace_interrupt(trace_interrupt), .buf_write_ptr(buf_write_ptr),
        .cfg_arm(cfg_arm), .cfg_disarm(cfg_disarm), .cfg_trig_mode(cfg_trig_mode),
        .cfg_trig_addr(cfg_trig_addr), .cfg_trig_mask(cfg_trig_mask),
        .cfg_post_count(cfg_post_count), .capture_en(capture_en), .state(state),
        .triggered(triggered), .trig_ptr(trig_ptr), .captured_cnt(captured_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hit();
        case (m_mode)
            0: return 1'b1;
            1: return (trace_address & m_mask) == (m_addr & m_mask);
            2: return trace_exception || trace_interrupt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear();
        m_state = 0; m_trig = 0; m_ptr = 0; m_cnt = 0; m_left = 0;
        m_mode = 0; m_post = 0; m_addr = '0; m_mask = '0;
    endtask

    task automatic model_step(input int cap);
        if (rst) begin
            model_clear();
            return;
        end
        if (cap != 0 && m_cnt < CNT_MAX) m_cnt++;
        if (!debug_en || cfg_disarm) begin
            m_state = 0;
        end else if (cfg_arm && (m_state == 0 || m_state == 3)) begin
            m_mode = int'(cfg_trig_mode); m_addr = cfg_trig_addr;
            m_mask = cfg_trig_mask;       m_post = int'(cfg_post_count);
            m_trig = 0; m_ptr = 0; m_cnt = 0; m_state = 1;
        end else if (m_state == 1 && cap != 0 && model_hit()) begin
            m_trig = 1;
            m_ptr  = int'(buf_write_ptr);
            if (m_post == 0) m_state = 3;
            else begin
                m_left  = m_post;
                m_state = 2;
            end
        end else if (m_state == 2 && cap != 0) begin
            m_left--;
            if (m_left == 0) m_state = 3;
        end
    endtask

    // Compare every output at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        int exp_cap;
        @(negedge clk);
        exp_cap = (trace_valid && debug_en && (m_state == 1 || m_state == 2)) ? 1 : 0;
        chk("capture_en",   32'(capture_en),   32'(exp_cap));
        chk("state",        32'(state),        32'(m_state));
        chk("triggered",    32'(triggered),    32'(m_trig));
        chk("trig_ptr",     32'(trig_ptr),     32'(m_ptr));
        chk("captured_cnt", 32'(captured_cnt), 32'(m_cnt));
        model_step(exp_cap);
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [1:0] mode, input logic [31:0] addr,
                       input logic [31:0] mask, input int post);
        cfg_trig_mode = mode; cfg_trig_addr = addr; cfg_trig_mask = mask;
        cfg_post_count = CW'(post);
        cfg_arm = 1'b1; trace_valid = 1'b0;
        tick();
        cfg_arm = 1'b0;
    endtask

    task automatic pkt(input logic [31:0] addr, input logic [PW-1:0] ptr, input logic irq);
        trace_valid = 1'b1; trace_address = addr; buf_write_ptr = ptr;
        trace_interrupt = irq;
        tick();
        trace_valid = 1'b0; trace_interrupt = 1'b0;
    endtask

    initial begin
        rst = 1'b1; debug_en = 1'b1; trace_valid = 1'b0; trace_address = '0;
        trace_exception = 1'b0; trace_interrupt = 1'b0; buf_write_ptr = '0;
        cfg_arm = 1'b0; cfg_disarm = 1'b0; cfg_trig_mode = '0; cfg_trig_addr = '0;
        cfg_trig_mask = '0; cfg_post_count = '0;
        model_clear();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Immediate trigger, post_count=3
        arm(2'd0, 32'h0, 32'h0, 3);
        for (int i = 0; i < 5; i++) pkt(32'h100 + 32'(i), PW'(10 + i), 1'b0);
        tick();
        chk("imm_state", 32'(state), 32'd3);
        chk("imm_trig_ptr", 32'(trig_ptr), 32'd10);
        chk("imm_cnt", 32'(captured_cnt), 32'd4);

        // Address-mask trigger, post_count=2
        arm(2'd1, 32'h2000_0100, 32'hFFFF_FF00, 2);
        pkt(32'h1000_0000, 6'd20, 1'b0);
        pkt(32'h2000_01F4, 6'd21, 1'b0);
        pkt(32'h2000_0000, 6'd22, 1'b0);
        pkt(32'h3000_0000, 6'd23, 1'b0);
        pkt(32'h4000_0000, 6'd24, 1'b0);
        chk("addr_state", 32'(state), 32'd3);
        chk("addr_trig_ptr", 32'(trig_ptr), 32'd21);
        chk("addr_cnt", 32'(captured_cnt), 32'd4);
        chk("addr_triggered", 32'(triggered), 32'd1);

        // Interrupt trigger, post_count=0
        arm(2'd2, 32'h0, 32'h0, 0);
        pkt(32'h0, 6'd30, 1'b0);
        pkt(32'h0, 6'd31, 1'b0);
        pkt(32'h0, 6'd32, 1'b1);
        chk("exc_state", 32'(state), 32'd3);
        pkt(32'h0, 6'd33, 1'b0);
        pkt(32'h0, 6'd34, 1'b1);
        chk("exc_cnt", 32'(captured_cnt), 32'd3);

        // Disarm alongside a packet in POST, then debug_en drop in ARMED
        arm(2'd0, 32'h0, 32'h0, 5);
        pkt(32'h0, 6'd40, 1'b0);
        cfg_disarm = 1'b1;
        pkt(32'h0, 6'd41, 1'b0);
        cfg_disarm = 1'b0;
        chk("dis_state", 32'(state), 32'd0);
        chk("dis_triggered", 32'(triggered), 32'd1);
        chk("dis_cnt", 32'(captured_cnt), 32'd2);
        arm(2'd3, 32'h0, 32'h0, 5);
        debug_en = 1'b0;
        pkt(32'h0, 6'd42, 1'b0);
        debug_en = 1'b1;
        chk("dbg_state", 32'(state), 32'd0);

        // Arm ignored in POST, then reset mid-POST
        arm(2'd0, 32'h0, 32'h0, 5);
        pkt(32'h0, 6'd50, 1'b0);
        cfg_arm = 1'b1;
        pkt(32'h0, 6'd51, 1'b0);
        cfg_arm = 1'b0;
        pkt(32'h0, 6'd52, 1'b0);
        chk("armign_state", 32'(state), 32'd2);
        chk("armign_cnt", 32'(captured_cnt), 32'd3);
        rst = 1'b1;
        pkt(32'h0, 6'd53, 1'b0);
        rst = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        chk("rst_trig_ptr", 32'(trig_ptr), 32'd0);
        chk("rst_cnt", 32'(captured_cnt), 32'd0);

        // Reserved mode never triggers; counter saturates
        arm(2'd3, 32'h0, 32'h0, 1);
        for (int i = 0; i < 20; i++) pkt(32'(i), PW'(60 + i), 1'b0);
        chk("sat_cnt", 32'(captured_cnt), 32'(CNT_MAX));
        chk("sat_state", 32'(state), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            debug_en        = ($urandom_range(0, 39) != 0);
            cfg_arm         = ($urandom_range(0, 11) == 0);
            cfg_disarm      = ($urandom_range(0, 29) == 0);
            cfg_trig_mode   = 2'($urandom_range(0, 3));
            cfg_trig_addr   = ($urandom_range(0, 1) == 0) ? 32'h2000_0100 : 32'h0000_0040;
            case ($urandom_range(0, 2))
                0:       cfg_trig_mask = 32'hFFFF_FF00;
                1:       cfg_trig_mask = 32'hFFFF_FFFF;
                default: cfg_trig_mask = 32'h0000_0000;
            endcase
            cfg_post_count  = CW'($urandom_range(0, 6));
            trace_valid     = ($urandom_range(0, 9) < 7);
            trace_address   = ($urandom_range(0, 1) == 0) ?
                              (m_addr ^ 32'($urandom_range(0, 255))) : 32'($urandom);
            trace_exception = ($urandom_range(0, 7) == 0);
            trace_interrupt = ($urandom_range(0, 7) == 0);
            buf_write_ptr   = buf_write_ptr + PW'(1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
